// File: rtl/lsu_mem_stage_pkg.sv
// Shared encodings for the load/store unit: controller load/store codes,
// FSM state encoding and the access-size helpers used for byte enables.
package lsu_mem_stage_pkg;

   localparam logic [2:0] MEM_READ_NONE  = 3'b000;
   localparam logic [2:0] MEM_READ_BYTE  = 3'b001;
   localparam logic [2:0] MEM_READ_HALF  = 3'b010;
   localparam logic [2:0] MEM_READ_WORD  = 3'b011;
   localparam logic [2:0] MEM_READ_BYTEU = 3'b100;
   localparam logic [2:0] MEM_READ_HALFU = 3'b101;

   localparam logic [1:0] MEM_WRITE_NONE = 2'b00;
   localparam logic [1:0] MEM_WRITE_BYTE = 2'b01;
   localparam logic [1:0] MEM_WRITE_HALF = 2'b10;
   localparam logic [1:0] MEM_WRITE_WORD = 2'b11;

   typedef enum logic [1:0] {
      LSU_ST_IDLE = 2'd0,
      LSU_ST_REQ  = 2'd1,
      LSU_ST_WAIT = 2'd2,
      LSU_ST_DONE = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsu_size_e;

   // Undefined load codes fall back to a full word access.
   function automatic lsu_size_e read_size(input logic [2:0] code);
      case (code)
         MEM_READ_BYTE, MEM_READ_BYTEU: read_size = SZ_BYTE;
         MEM_READ_HALF, MEM_READ_HALFU: read_size = SZ_HALF;
         default:                       read_size = SZ_WORD;
      endcase
   endfunction

   function automatic lsu_size_e write_size(input logic [1:0] code);
      case (code)
         MEM_WRITE_BYTE: write_size = SZ_BYTE;
         MEM_WRITE_HALF: write_size = SZ_HALF;
         default:        write_size = SZ_WORD;
      endcase
   endfunction

   // Halves look only at addr[1]; words ignore the low bits (forced alignment).
   function automatic logic [3:0] lsu_byte_en(input lsu_size_e sz, input logic [1:0] a);
      case (sz)
         SZ_BYTE: lsu_byte_en = 4'b0001 << a;
         SZ_HALF: lsu_byte_en = a[1] ? 4'b1100 : 4'b0011;
         default: lsu_byte_en = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Load lane select and sign/zero extension of the returned memory word.
module lsu_load_align
   import lsu_mem_stage_pkg::*;
(
   input  logic [2:0]  code_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Pick the addressed lane, then extend according to the load code.
   always_comb begin
      byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
      half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      data_o = rdata_i;
      case (code_i)
         MEM_READ_BYTE:  data_o = {{24{byte_v[7]}}, byte_v};
         MEM_READ_BYTEU: data_o = {24'h000000, byte_v};
         MEM_READ_HALF:  data_o = {{16{half_v[15]}}, half_v};
         MEM_READ_HALFU: data_o = {16'h0000, half_v};
         default:        data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// Multi-cycle load/store unit with a req/gnt/rvalid data-memory port.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no memory request, o_misaligned pulse) instead of force-aligning.
//
// state | meaning
// IDLE  | no access in flight; accept a new access (stall combinationally)
// REQ   | request held stable until gnt
// WAIT  | load granted, waiting for rvalid
// DONE  | one-cycle completion; stall released, inputs ignored
module lsu_mem_stage
   import lsu_mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   input  logic [2:0]        i_mem_read,
   input  logic [1:0]        i_mem_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   output logic              o_stall,
   output logic [31:0]       o_rdata,
   output logic              o_rdata_valid,
   output logic              o_dmem_req,
   output logic              o_dmem_we,
   output logic [ADDR_W-1:0] o_dmem_addr,
   output logic [3:0]        o_dmem_be,
   output logic [31:0]       o_dmem_wdata,
   input  logic              i_dmem_gnt,
   input  logic              i_dmem_rvalid,
   input  logic [31:0]       i_dmem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
   ,
   output logic              o_misaligned
`endif
);

   lsu_state_e        state_q, state_d;
   logic              load_q;
   logic [2:0]        rcode_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;

   logic              access;
   logic              is_load;
   lsu_size_e         size_in;
   logic [31:0]       wdata_in;
   logic              misal_in;
   logic [31:0]       align_data;

   // Decode the incoming instruction into access size, enables and lane data.
   always_comb begin
      access   = i_valid && ((i_mem_read != MEM_READ_NONE) || (i_mem_write != MEM_WRITE_NONE));
      is_load  = (i_mem_read != MEM_READ_NONE);
      size_in  = is_load ? read_size(i_mem_read) : write_size(i_mem_write);
      wdata_in = i_wdata;
      case (size_in)
         SZ_BYTE: wdata_in = {4{i_wdata[7:0]}};
         SZ_HALF: wdata_in = {2{i_wdata[15:0]}};
         default: wdata_in = i_wdata;
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      misal_in = ((size_in == SZ_HALF) && i_addr[0]) ||
                 ((size_in == SZ_WORD) && (i_addr[1:0] != 2'b00));
`else
      misal_in = 1'b0;
`endif
   end

   // Next-state logic; loads win over stores, misaligned traps skip memory.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_ST_IDLE: if (access) state_d = misal_in ? LSU_ST_DONE : LSU_ST_REQ;
         LSU_ST_REQ:  if (i_dmem_gnt) state_d = load_q ? LSU_ST_WAIT : LSU_ST_DONE;
         LSU_ST_WAIT: if (i_dmem_rvalid) state_d = LSU_ST_DONE;
         LSU_ST_DONE: state_d = LSU_ST_IDLE;
         default:     state_d = LSU_ST_IDLE;
      endcase
   end

   // State register; reset mid-access drops the request immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= LSU_ST_IDLE;
      else        state_q <= state_d;
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic misal_q;

   // Remember whether the accepted access trapped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   misal_q <= 1'b0;
      else if ((state_q == LSU_ST_IDLE) && access) misal_q <= misal_in;
   end

   assign o_misaligned  = (state_q == LSU_ST_DONE) && misal_q;
   assign o_rdata_valid = (state_q == LSU_ST_DONE) && !misal_q;
`else
   assign o_rdata_valid = (state_q == LSU_ST_DONE);
`endif

   // Latch the access on accept and capture extended load data on rvalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_q  <= 1'b0;
         rcode_q <= MEM_READ_NONE;
         addr_q  <= '0;
         be_q    <= 4'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         if ((state_q == LSU_ST_IDLE) && access) begin
            load_q  <= is_load;
            rcode_q <= i_mem_read;
            addr_q  <= i_addr;
            be_q    <= lsu_byte_en(size_in, i_addr[1:0]);
            wdata_q <= is_load ? 32'h0 : wdata_in;
            rdata_q <= 32'h0;
         end else if ((state_q == LSU_ST_WAIT) && i_dmem_rvalid) begin
            rdata_q <= align_data;
         end
      end
   end

   lsu_load_align u_align (
      .code_i    (rcode_q),
      .addr_lo_i (addr_q[1:0]),
      .rdata_i   (i_dmem_rdata),
      .data_o    (align_data)
   );

   assign o_stall      = rst_n && (((state_q == LSU_ST_IDLE) && access) ||
                                   (state_q == LSU_ST_REQ) || (state_q == LSU_ST_WAIT));
   assign o_dmem_req   = (state_q == LSU_ST_REQ);
   assign o_dmem_we    = (state_q == LSU_ST_REQ) && !load_q;
   assign o_dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign o_dmem_be    = be_q;
   assign o_dmem_wdata = wdata_q;
   assign o_rdata      = rdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage.
module tb_lsu_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic [2:0]  i_mem_read = 3'b000;
   logic [1:0]  i_mem_write = 2'b00;
   logic [31:0] i_addr = 32'h0;
   logic [31:0] i_wdata = 32'h0;
   logic        o_stall;
   logic [31:0] o_rdata;
   logic        o_rdata_valid;
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic [31:0] o_dmem_addr;
   logic [3:0]  o_dmem_be;
   logic [31:0] o_dmem_wdata;
   logic        i_dmem_gnt = 1'b0;
   logic        i_dmem_rvalid = 1'b0;
   logic [31:0] i_dmem_rdata = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        o_misaligned;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int stall_cnt;

   always #5 clk = ~clk;

   lsu_mem_stage #(.ADDR_W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_valid       (i_valid),
      .i_mem_read    (i_mem_read),
      .i_mem_write   (i_mem_write),
      .i_addr        (i_addr),
      .i_wdata       (i_wdata),
      .o_stall       (o_stall),
      .o_rdata       (o_rdata),
      .o_rdata_valid (o_rdata_valid),
      .o_dmem_req    (o_dmem_req),
      .o_dmem_we     (o_dmem_we),
      .o_dmem_addr   (o_dmem_addr),
      .o_dmem_be     (o_dmem_be),
      .o_dmem_wdata  (o_dmem_wdata),
      .i_dmem_gnt    (i_dmem_gnt),
      .i_dmem_rvalid (i_dmem_rvalid),
      .i_dmem_rdata  (i_dmem_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
      ,
      .o_misaligned  (o_misaligned)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge, then drive inputs; checks follow after #1.
   task automatic drive(input logic v, input logic [2:0] rd, input logic [1:0] wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic g, input logic rv, input logic [31:0] rdat);
      @(negedge clk);
      i_valid = v; i_mem_read = rd; i_mem_write = wr; i_addr = a; i_wdata = wd;
      i_dmem_gnt = g; i_dmem_rvalid = rv; i_dmem_rdata = rdat;
      #1;
   endtask

   initial begin
      // Reset with a load presented: everything low, stall forced off.
      i_valid = 1'b1; i_mem_read = 3'b011; i_addr = 32'h40;
      #2;
      chk("rst_stall", {31'b0, o_stall}, 32'd0);
      chk("rst_req", {31'b0, o_dmem_req}, 32'd0);
      chk("rst_rvalid_o", {31'b0, o_rdata_valid}, 32'd0);
      chk("rst_rdata", o_rdata, 32'h0);
      chk("rst_addr", o_dmem_addr, 32'h0);
      chk("rst_be", {28'b0, o_dmem_be}, 32'h0);
      chk("rst_wdata", o_dmem_wdata, 32'h0);
      @(negedge clk); @(negedge clk);
      i_valid = 1'b0; i_mem_read = 3'b000;
      rst_n = 1'b1;

      // ADD: no stall, no request.
      drive(1, 3'b000, 2'b00, 32'h104, 32'h0, 0, 0, 32'h0);
      chk("add_stall", {31'b0, o_stall}, 32'd0);
      drive(1, 3'b000, 2'b00, 32'h108, 32'h0, 0, 0, 32'h0);
      chk("add_req", {31'b0, o_dmem_req}, 32'd0);
      chk("add_stall2", {31'b0, o_stall}, 32'd0);

      // LB 0x103, rdata 0x80FF_1234, zero-wait.
      stall_cnt = 0;
      drive(1, 3'b001, 2'b00, 32'h103, 32'h0, 0, 0, 32'h0);
      stall_cnt += int'(o_stall);
      chk("lb_c0_stall", {31'b0, o_stall}, 32'd1);
      chk("lb_c0_req", {31'b0, o_dmem_req}, 32'd0);
      drive(1, 3'b001, 2'b00, 32'h103, 32'h0, 1, 0, 32'h0);
      stall_cnt += int'(o_stall);
      chk("lb_c1_req", {31'b0, o_dmem_req}, 32'd1);
      chk("lb_c1_we", {31'b0, o_dmem_we}, 32'd0);
      chk("lb_c1_addr", o_dmem_addr, 32'h100);
      chk("lb_c1_be", {28'b0, o_dmem_be}, 32'h8);
      drive(1, 3'b001, 2'b00, 32'h103, 32'h0, 0, 1, 32'h80FF1234);
      stall_cnt += int'(o_stall);
      chk("lb_c2_req", {31'b0, o_dmem_req}, 32'd0);
      chk("lb_c2_valid", {31'b0, o_rdata_valid}, 32'd0);
      drive(1, 3'b001, 2'b00, 32'h103, 32'h0, 0, 0, 32'h0);
      stall_cnt += int'(o_stall);
      chk("lb_c3_valid", {31'b0, o_rdata_valid}, 32'd1);
      chk("lb_c3_rdata", o_rdata, 32'hFFFFFF80);
      chk("lb_stall_cycles", stall_cnt, 32'd3);
      drive(0, 3'b000, 2'b00, 32'h0, 32'h0, 0, 0, 32'h0);
      chk("lb_c4_valid", {31'b0, o_rdata_valid}, 32'd0);

      // Spurious rvalid in IDLE has no effect.
      drive(0, 3'b000, 2'b00, 32'h0, 32'h0, 0, 1, 32'hDEADBEEF);
      chk("spur_valid0", {31'b0, o_rdata_valid}, 32'd0);
      drive(0, 3'b000, 2'b00, 32'h0, 32'h0, 0, 0, 32'h0);
      chk("spur_valid1", {31'b0, o_rdata_valid}, 32'd0);
      chk("spur_stall", {31'b0, o_stall}, 32'd0);

      // LHU 0x006, rdata 0x8001_0000, rvalid 3 cycles after gnt.
      drive(1, 3'b101, 2'b00, 32'h006, 32'h0, 0, 0, 32'h0);
      drive(1, 3'b101, 2'b00, 32'h006, 32'h0, 1, 0, 32'h0);
      chk("lhu_addr", o_dmem_addr, 32'h4);
      chk("lhu_be", {28'b0, o_dmem_be}, 32'hC);
      drive(1, 3'b101, 2'b00, 32'h006, 32'h0, 0, 0, 32'h0);
      chk("lhu_w1_stall", {31'b0, o_stall}, 32'd1);
      drive(1, 3'b101, 2'b00, 32'h006, 32'h0, 0, 0, 32'h0);
      chk("lhu_w2_valid", {31'b0, o_rdata_valid}, 32'd0);
      drive(1, 3'b101, 2'b00, 32'h006, 32'h0, 0, 1, 32'h80010000);
      chk("lhu_w3_stall", {31'b0, o_stall}, 32'd1);
      drive(1, 3'b101, 2'b00, 32'h006, 32'h0, 0, 0, 32'h0);
      chk("lhu_valid", {31'b0, o_rdata_valid}, 32'd1);
      chk("lhu_rdata", o_rdata, 32'h00008001);
      chk("lhu_stall_done", {31'b0, o_stall}, 32'd0);

      // SH 0x202, wdata 0xBEEF, gnt delayed two cycles.
      drive(1, 3'b000, 2'b10, 32'h202, 32'h0000BEEF, 0, 0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         drive(1, 3'b000, 2'b10, 32'h202, 32'h0000BEEF, (k == 2), 0, 32'h0);
         chk("sh_req", {31'b0, o_dmem_req}, 32'd1);
         chk("sh_we", {31'b0, o_dmem_we}, 32'd1);
         chk("sh_addr", o_dmem_addr, 32'h200);
         chk("sh_be", {28'b0, o_dmem_be}, 32'hC);
         chk("sh_wdata", o_dmem_wdata, 32'hBEEFBEEF);
         chk("sh_stall", {31'b0, o_stall}, 32'd1);
      end
      drive(1, 3'b000, 2'b10, 32'h202, 32'h0000BEEF, 0, 0, 32'h0);
      chk("sh_done_stall", {31'b0, o_stall}, 32'd0);
      chk("sh_done_req", {31'b0, o_dmem_req}, 32'd0);

      // SB 0x001: single lane enable, replicated byte.
      drive(1, 3'b000, 2'b01, 32'h001, 32'h123456A5, 0, 0, 32'h0);
      drive(1, 3'b000, 2'b01, 32'h001, 32'h123456A5, 1, 0, 32'h0);
      chk("sb_be", {28'b0, o_dmem_be}, 32'h2);
      chk("sb_wdata", o_dmem_wdata, 32'hA5A5A5A5);
      drive(1, 3'b000, 2'b01, 32'h001, 32'h123456A5, 0, 0, 32'h0);
      chk("sb_done_stall", {31'b0, o_stall}, 32'd0);

      // Load and store codes together: the load wins.
      drive(1, 3'b011, 2'b11, 32'h010, 32'hFFFFFFFF, 0, 0, 32'h0);
      drive(1, 3'b011, 2'b11, 32'h010, 32'hFFFFFFFF, 1, 0, 32'h0);
      chk("both_we", {31'b0, o_dmem_we}, 32'd0);
      chk("both_be", {28'b0, o_dmem_be}, 32'hF);
      drive(1, 3'b011, 2'b11, 32'h010, 32'hFFFFFFFF, 0, 1, 32'h12345678);
      drive(1, 3'b011, 2'b11, 32'h010, 32'hFFFFFFFF, 0, 0, 32'h0);
      chk("both_rdata", o_rdata, 32'h12345678);
      chk("both_valid", {31'b0, o_rdata_valid}, 32'd1);

      // Reset while in WAIT; the late response is discarded.
      drive(1, 3'b011, 2'b00, 32'h020, 32'h0, 0, 0, 32'h0);
      drive(1, 3'b011, 2'b00, 32'h020, 32'h0, 1, 0, 32'h0);
      drive(1, 3'b011, 2'b00, 32'h020, 32'h0, 0, 0, 32'h0);
      chk("rw_wait_stall", {31'b0, o_stall}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rw_rst_req", {31'b0, o_dmem_req}, 32'd0);
      chk("rw_rst_stall", {31'b0, o_stall}, 32'd0);
      drive(0, 3'b000, 2'b00, 32'h0, 32'h0, 0, 1, 32'hAAAA5555);
      rst_n = 1'b1;
      #1;
      chk("rw_late_valid", {31'b0, o_rdata_valid}, 32'd0);
      drive(0, 3'b000, 2'b00, 32'h0, 32'h0, 0, 0, 32'h0);
      chk("rw_late_valid2", {31'b0, o_rdata_valid}, 32'd0);
      chk("rw_req", {31'b0, o_dmem_req}, 32'd0);
      chk("rw_rdata", o_rdata, 32'h0);

      // LW 0x102: trap or forced alignment depending on build.
      drive(1, 3'b011, 2'b00, 32'h102, 32'h0, 0, 0, 32'h0);
      chk("lw_c0_stall", {31'b0, o_stall}, 32'd1);
`ifdef LSU_MISALIGN_TRAP_EN
      drive(1, 3'b011, 2'b00, 32'h102, 32'h0, 0, 0, 32'h0);
      chk("lw_trap_req", {31'b0, o_dmem_req}, 32'd0);
      chk("lw_trap_mis", {31'b0, o_misaligned}, 32'd1);
      chk("lw_trap_valid", {31'b0, o_rdata_valid}, 32'd0);
      chk("lw_trap_rdata", o_rdata, 32'h0);
      chk("lw_trap_stall", {31'b0, o_stall}, 32'd0);
      drive(0, 3'b000, 2'b00, 32'h0, 32'h0, 0, 0, 32'h0);
      chk("lw_trap_mis_end", {31'b0, o_misaligned}, 32'd0);
`else
      drive(1, 3'b011, 2'b00, 32'h102, 32'h0, 1, 0, 32'h0);
      chk("lw_req", {31'b0, o_dmem_req}, 32'd1);
      chk("lw_addr", o_dmem_addr, 32'h100);
      chk("lw_be", {28'b0, o_dmem_be}, 32'hF);
      drive(1, 3'b011, 2'b00, 32'h102, 32'h0, 0, 1, 32'hCAFEF00D);
      drive(1, 3'b011, 2'b00, 32'h102, 32'h0, 0, 0, 32'h0);
      chk("lw_rdata", o_rdata, 32'hCAFEF00D);
      chk("lw_valid", {31'b0, o_rdata_valid}, 32'd1);
`endif
      drive(0, 3'b000, 2'b00, 32'h0, 32'h0, 0, 0, 32'h0);
      chk("end_stall", {31'b0, o_stall}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
